fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register feeding the decode stage, where op_d drives the main decoder and funct_d drives the ALU decoder. Holds the fetch PC and issues one instruction-memory request at a time. Buffers a returned word while decode is stalled. Handles branch/jump redirects and decode flushes.

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with a single-outstanding imem request, one-entry skid
// buffer for stalled returns, redirect/discard handling and the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic [5:0]  op_d,
  output logic [5:0]  funct_d
);

  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic        discard;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] redirect_tgt;
  logic        take_word;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // A word reaches IF/ID either straight from memory or from the skid buffer.
  always_comb begin
    take_word  = (state == WAIT) && imem_rvalid && !discard && !redirect;
    load       = !stall_d && (take_word || ((state == HOLD) && !redirect));
    load_instr = (state == HOLD) ? skid_instr : imem_rdata;
    load_pc    = (state == HOLD) ? skid_pc : pc_f;
  end

  assign imem_req  = rst_n && (state == ISSUE) && !redirect;
  assign imem_addr = pc_f;

  // Fetch FSM: redirect overrides everything and reaims pc_f.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ISSUE;
      pc_f       <= RESET_PC;
      discard    <= 1'b0;
      skid_instr <= 32'h0;
      skid_pc    <= 32'h0;
    end else if (redirect) begin
      pc_f <= redirect_tgt;
      case (state)
        ISSUE: state <= ISSUE;
        WAIT: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            state   <= ISSUE;
          end else begin
            discard <= 1'b1;
          end
        end
        HOLD:    state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end else begin
      case (state)
        ISSUE: state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= ISSUE;
            end else if (stall_d) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc_f;
              state      <= HOLD;
            end else begin
              pc_f  <= pc_f + 32'd4;
              state <= ISSUE;
            end
          end
        end
        HOLD: begin
          if (!stall_d) begin
            pc_f  <= pc_f + 32'd4;
            state <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

  // IF/ID register: flush beats stall beats load; otherwise insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d   <= 32'h0;
      pc_d      <= 32'h0;
      pcplus4_d <= 32'h0;
      valid_d   <= 1'b0;
    end else if (flush_d) begin
      instr_d <= 32'h0;
      valid_d <= 1'b0;
    end else if (stall_d) begin
      instr_d <= instr_d;
      valid_d <= valid_d;
    end else if (load) begin
      instr_d   <= load_instr;
      pc_d      <= load_pc;
      pcplus4_d <= load_pc + 32'd4;
      valid_d   <= 1'b1;
    end else begin
      instr_d <= 32'h0;
      valid_d <= 1'b0;
    end
  end

  assign op_d    = instr_d[31:26];
  assign funct_d = instr_d[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-by-cycle bench for fetch_stage; a second instance covers the
// wrapping reset PC.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_d, flush_d, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        valid_d;
  logic [5:0]  op_d, funct_d;

  logic        req1, rvalid1;
  logic [31:0] addr1, rdata1, instr1, pc1, pcp41;
  logic        valid1;
  logic [5:0]  op1, funct1;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_d(flush_d),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
    .op_d(op_d), .funct_d(funct_d)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_d(1'b0), .flush_d(1'b0),
    .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(req1), .imem_addr(addr1),
    .imem_rvalid(rvalid1), .imem_rdata(rdata1),
    .instr_d(instr1), .pc_d(pc1), .pcplus4_d(pcp41), .valid_d(valid1),
    .op_d(op1), .funct_d(funct1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1;
    stall_d = 0; flush_d = 0; redirect = 0; redirect_pc = 32'h0;
    imem_rvalid = 0; imem_rdata = 32'h0;
    rvalid1 = 0; rdata1 = 32'h0;
    #1 rst_n = 1'b0;
    tick(); tick();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, valid_d}, 32'h0);
    check("rst_instr", instr_d, 32'h0);
    check("rst_pc", pc_d, 32'h0);
    check("rst_pcp4", pcplus4_d, 32'h0);

    // C0: first cycle out of reset issues at RESET_PC
    rst_n = 1'b1; #1;
    check("c0_req", {31'h0, imem_req}, 32'h1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_req_wrap", {31'h0, req1}, 32'h1);
    check("c0_addr_wrap", addr1, 32'hFFFF_FFFC);

    // C1: WAIT, latency-1 response
    tick();
    imem_rvalid = 1; imem_rdata = 32'h3C01_1234;
    rvalid1 = 1; rdata1 = 32'hAAAA_0001; #1;
    check("c1_req", {31'h0, imem_req}, 32'h0);

    // C2: word visible in IF/ID, next request at +4
    tick();
    imem_rvalid = 0; rvalid1 = 0; #1;
    check("c2_instr", instr_d, 32'h3C01_1234);
    check("c2_valid", {31'h0, valid_d}, 32'h1);
    check("c2_pc", pc_d, 32'h0);
    check("c2_pcp4", pcplus4_d, 32'h4);
    check("c2_op", {26'h0, op_d}, 32'h0F);
    check("c2_funct", {26'h0, funct_d}, 32'h34);
    check("c2_req", {31'h0, imem_req}, 32'h1);
    check("c2_addr", imem_addr, 32'h4);
    check("c2_pc_wrap", pc1, 32'hFFFF_FFFC);
    check("c2_pcp4_wrap", pcp41, 32'h0);
    check("c2_addr_wrap", addr1, 32'h0);
    check("c2_req_wrap", {31'h0, req1}, 32'h1);

    // C3: WAIT, response for 0x4
    tick();
    imem_rvalid = 1; imem_rdata = 32'h3421_5678; #1;

    // C4: second word loaded; stall begins (request still issues)
    tick();
    imem_rvalid = 0; stall_d = 1; #1;
    check("c4_instr", instr_d, 32'h3421_5678);
    check("c4_pc", pc_d, 32'h4);
    check("c4_op", {26'h0, op_d}, 32'h0D);
    check("c4_req_stall", {31'h0, imem_req}, 32'h1);
    check("c4_addr", imem_addr, 32'h8);

    // C5: response arrives while stalled
    tick();
    imem_rvalid = 1; imem_rdata = 32'h3021_00FF; #1;
    check("c5_instr_hold", instr_d, 32'h3421_5678);

    // C6: HOLD, still stalled
    tick();
    imem_rvalid = 0; #1;
    check("c6_instr_hold", instr_d, 32'h3421_5678);
    check("c6_valid", {31'h0, valid_d}, 32'h1);
    check("c6_no_req", {31'h0, imem_req}, 32'h0);

    // C7: stall released
    tick();
    stall_d = 0; #1;
    check("c7_instr_hold", instr_d, 32'h3421_5678);
    check("c7_no_req", {31'h0, imem_req}, 32'h0);

    // C8: buffered word loaded, next request at 0xC
    tick(); #1;
    check("c8_instr", instr_d, 32'h3021_00FF);
    check("c8_pc", pc_d, 32'h8);
    check("c8_valid", {31'h0, valid_d}, 32'h1);
    check("c8_req", {31'h0, imem_req}, 32'h1);
    check("c8_addr", imem_addr, 32'hC);

    // C9: redirect while WAIT (target low bits forced to 00)
    tick();
    redirect = 1; redirect_pc = 32'h0000_0103; #1;
    check("c9_req", {31'h0, imem_req}, 32'h0);
    check("c9_valid_bubble", {31'h0, valid_d}, 32'h0);

    tick();
    redirect = 0; #1;
    check("c10_no_req", {31'h0, imem_req}, 32'h0);

    // C11: stale response (latency 3) must be dropped
    tick();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; #1;

    tick();
    imem_rvalid = 0; #1;
    check("c12_valid", {31'h0, valid_d}, 32'h0);
    check("c12_instr", instr_d, 32'h0);
    check("c12_req", {31'h0, imem_req}, 32'h1);
    check("c12_addr", imem_addr, 32'h100);

    tick();
    imem_rvalid = 1; imem_rdata = 32'h8C22_0000; #1;

    // C14: redirected word arrives; flush+stall together
    tick();
    imem_rvalid = 0; #1;
    check("c14_instr", instr_d, 32'h8C22_0000);
    check("c14_pc", pc_d, 32'h100);
    check("c14_op", {26'h0, op_d}, 32'h23);
    check("c14_addr", imem_addr, 32'h104);
    flush_d = 1; stall_d = 1;

    tick();
    flush_d = 0; stall_d = 0;
    imem_rvalid = 1; imem_rdata = 32'h0022_1820; #1;
    check("c15_valid_flush", {31'h0, valid_d}, 32'h0);
    check("c15_instr_flush", instr_d, 32'h0);
    check("c15_pc_keep", pc_d, 32'h100);
    check("c15_pcp4_keep", pcplus4_d, 32'h104);

    tick();
    imem_rvalid = 0; #1;
    check("c16_instr", instr_d, 32'h0022_1820);
    check("c16_pc", pc_d, 32'h104);
    check("c16_funct", {26'h0, funct_d}, 32'h20);
    check("c16_op", {26'h0, op_d}, 32'h00);
    check("c16_addr", imem_addr, 32'h108);

    // C17: reset asserted mid-WAIT
    tick();
    rst_n = 0; #1;
    check("c17_rst_req", {31'h0, imem_req}, 32'h0);
    check("c17_rst_valid", {31'h0, valid_d}, 32'h0);
    check("c17_rst_instr", instr_d, 32'h0);
    check("c17_rst_pc", pc_d, 32'h0);
    check("c17_rst_pcp4", pcplus4_d, 32'h0);

    // C18: out of reset, late response lands in ISSUE and is ignored
    tick();
    rst_n = 1; imem_rvalid = 1; imem_rdata = 32'hFFFF_FFFF; #1;
    check("c18_req", {31'h0, imem_req}, 32'h1);
    check("c18_addr", imem_addr, 32'h0);

    tick();
    imem_rvalid = 1; imem_rdata = 32'h2442_0001; #1;
    check("c19_valid", {31'h0, valid_d}, 32'h0);
    check("c19_instr", instr_d, 32'h0);

    tick();
    imem_rvalid = 0; #1;
    check("c20_instr", instr_d, 32'h2442_0001);
    check("c20_pc", pc_d, 32'h0);
    check("c20_valid", {31'h0, valid_d}, 32'h1);
    check("c20_addr", imem_addr, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
